// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: turns one-cycle button strobes into register-file and ALU
// control. Every output is registered. The ALU start/done handshake is
// guarded by a timeout.
module calc_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       pb,
  output logic [WIDTH-1:0] entry,
  output logic             rf_we,
  output logic [1:0]       rf_waddr,
  output logic [1:0]       rf_raddr_a,
  output logic [1:0]       rf_raddr_b,
  output logic             alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic             alu_ovf,
  output logic             disp_sel,
  output logic             blue,
  output logic             red
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_A, S_RD_B, S_RD_OP, S_EXEC, S_SHOW, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic             we_q, we_d, start_q, start_d, op_q, op_d;
  logic [1:0]       waddr_q, waddr_d, ra_q, ra_d, rb_q, rb_d;
  logic             disp_q, disp_d, blue_q, blue_d, red_q, red_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // A strobe is acted on only if exactly one button bit is set.
  logic       pb_one;
  logic       sel_hit;
  logic [1:0] sel_idx;
  assign pb_one  = (pb != 10'd0) && ((pb & (pb - 10'd1)) == 10'd0);
  assign sel_hit = |pb[9:6];
  assign sel_idx = pb[7] ? 2'd1 : pb[8] ? 2'd2 : pb[9] ? 2'd3 : 2'd0;

  // Next-state and output decode; strobes are one-shot, so rf_we and
  // alu_start default low each cycle.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    we_d    = 1'b0;
    start_d = 1'b0;
    op_d    = op_q;
    waddr_d = waddr_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    disp_d  = disp_q;
    red_d   = red_q;
    cnt_d   = cnt_q;
    if (state_q == S_EXEC) begin
      // Buttons are ignored here. If done arrives on the last count it
      // takes priority over the timeout.
      if (alu_done) begin
        red_d   = alu_ovf;
        disp_d  = 1'b1;
        state_d = S_SHOW;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        red_d   = 1'b1;
        state_d = S_ERR;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pb_one) begin
      // Write mode always starts from a clear entry, whatever state it is
      // entered from.
      if (pb[2]) begin
        entry_d = '0;
        disp_d  = 1'b0;
        red_d   = 1'b0;
        state_d = S_WRITE;
      end else begin
        unique case (state_q)
          S_IDLE:  if (pb[3]) state_d = S_RD_A;
          S_WRITE: begin
            if (pb[0] || pb[1]) entry_d = {entry_q[WIDTH-2:0], pb[1]};
            else if (pb[3]) state_d = S_RD_A;
            else if (sel_hit && !we_q) begin
              // Back-to-back register writes are dropped.
              we_d    = 1'b1;
              waddr_d = sel_idx;
              entry_d = '0;
            end
          end
          S_RD_A: if (sel_hit) begin ra_d = sel_idx; state_d = S_RD_B; end
          S_RD_B: if (sel_hit) begin rb_d = sel_idx; state_d = S_RD_OP; end
          S_RD_OP: if (pb[4] || pb[5]) begin
            op_d    = pb[5];
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = S_EXEC;
          end
          S_SHOW, S_ERR: if (pb[3]) begin
            disp_d  = 1'b0;
            red_d   = 1'b0;
            state_d = S_RD_A;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
    blue_d = (state_d == S_EXEC);
  end

  // State and output registers; reset clears everything to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      op_q    <= 1'b0;
      waddr_q <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      disp_q  <= 1'b0;
      blue_q  <= 1'b0;
      red_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      we_q    <= we_d;
      start_q <= start_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      disp_q  <= disp_d;
      blue_q  <= blue_d;
      red_q   <= red_d;
      cnt_q   <= cnt_d;
    end
  end

  assign entry      = entry_q;
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_raddr_a = ra_q;
  assign rf_raddr_b = rb_q;
  assign alu_op     = op_q;
  assign alu_start  = start_q;
  assign disp_sel   = disp_q;
  assign blue       = blue_q;
  assign red        = red_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: a driver applies directed and random stimulus
// and pushes the reference model's expected outputs into a queue. A monitor
// pops one entry per clock and compares it against the DUT.
module tb_calc_seq_ctrl;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       pb;
  logic [WIDTH-1:0] entry;
  logic             rf_we, alu_op, alu_start, alu_done, alu_ovf;
  logic             disp_sel, blue, red;
  logic [1:0]       rf_waddr, rf_raddr_a, rf_raddr_b;

  calc_seq_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pb(pb), .entry(entry), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_ovf(alu_ovf), .disp_sel(disp_sel), .blue(blue), .red(red)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] entry;
    logic             we;
    logic [1:0]       waddr, ra, rb;
    logic             op, start, disp, blue, red;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0, passed = 0;
  int   blue_run = 0, last_run = 0;

  // Reference model: the operating mode is held as a name string.
  string m_mode = "idle";
  obs_t  m;
  int    m_cyc = 0;

  function automatic void model_step(logic r, logic [9:0] b, logic d, logic v);
    int  k;
    bit  prev_we;
    prev_we = m.we;
    if (r) begin
      m = '0; m_mode = "idle"; m_cyc = 0;
      return;
    end
    m.we = 0; m.start = 0;
    if (m_mode == "exec") begin
      if (d) begin
        m.red = v; m.disp = 1; m_mode = "show";
      end else if (m_cyc == TIMEOUT - 1) begin
        m.red = 1; m_mode = "err";
      end else m_cyc++;
    end else if ($countones(b) == 1) begin
      k = $clog2(int'(b));
      if (k == 2) begin
        m.entry = 0; m.disp = 0; m.red = 0; m_mode = "write";
      end else if (m_mode == "idle") begin
        if (k == 3) m_mode = "rd_a";
      end else if (m_mode == "write") begin
        if (k <= 1) m.entry = {m.entry[WIDTH-2:0], k[0]};
        else if (k == 3) m_mode = "rd_a";
        else if (k >= 6 && !prev_we) begin
          m.we = 1; m.waddr = 2'(k - 6); m.entry = 0;
        end
      end else if (m_mode == "rd_a") begin
        if (k >= 6) begin m.ra = 2'(k - 6); m_mode = "rd_b"; end
      end else if (m_mode == "rd_b") begin
        if (k >= 6) begin m.rb = 2'(k - 6); m_mode = "rd_op"; end
      end else if (m_mode == "rd_op") begin
        if (k == 4 || k == 5) begin
          m.op = (k == 5); m.start = 1; m_cyc = 0; m_mode = "exec";
        end
      end else if (k == 3) begin // show or err
        m.disp = 0; m.red = 0; m_mode = "rd_a";
      end
    end
    m.blue = (m_mode == "exec");
  endfunction

  // One clock of stimulus: drive on the falling edge, then queue the outputs
  // expected after the next rising edge.
  task automatic cyc(logic r, logic [9:0] b, logic d = 0, logic v = 0);
    @(negedge clk);
    rst = r; pb = b; alu_done = d; alu_ovf = v;
    model_step(r, b, d, v);
    exp_q.push_back(m);
  endtask

  task automatic strobe(int k);
    cyc(0, 10'(1 << k));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 10'd0);
  endtask

  // Monitor: compare the DUT against the oldest expected entry each cycle.
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (blue) blue_run++;
    else if (blue_run != 0) begin last_run = blue_run; blue_run = 0; end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{entry, rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op,
            alu_start, disp_sel, blue, red};
      checks++;
      if (a === e) passed++;
      else $display("FAIL outputs t=%0t actual=%h expected=%h (entry,we,wa,ra,rb,op,start,disp,blue,red)",
                    $time, a, e);
    end
  end

  initial begin
    rst = 1; pb = 0; alu_done = 0; alu_ovf = 0;
    m = '0;
    // Reset held for three cycles.
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    // Write path: entry 8'h01 to r0, then 8'h02 to r1.
    strobe(2); repeat (8) strobe(0); strobe(1); strobe(6); idle(1);
    strobe(1); strobe(0); strobe(7); idle(1);
    // ADD r0,r1; done three cycles after start.
    strobe(3); strobe(6); strobe(7); strobe(4); idle(2); cyc(0, 0, 1, 0); idle(1);
    // SUB with overflow, then clear from SHOW.
    strobe(3); strobe(6); strobe(7); strobe(5); idle(1); cyc(0, 0, 1, 1); idle(1);
    strobe(3); idle(1);
    // Timeout with no done.
    strobe(6); strobe(7); strobe(4); idle(TIMEOUT + 3);
    checks++;
    if (last_run == TIMEOUT) passed++;
    else $display("FAIL timeout_blue_cycles actual=%0d expected=%0d", last_run, TIMEOUT);
    // Done on the last timeout cycle wins.
    strobe(3); strobe(6); strobe(7); strobe(4); idle(TIMEOUT - 1); cyc(0, 0, 1, 1); idle(1);
    // Illegal and out-of-state strobes in WRITE.
    strobe(2); strobe(1); cyc(0, 10'b0000000011); strobe(4); idle(1);
    // Strobes during EXEC, reset mid-EXEC, late done.
    strobe(3); strobe(6); strobe(7); strobe(4);
    strobe(4); strobe(5); strobe(2); strobe(3);
    cyc(1, 0); cyc(0, 0, 1, 1); idle(2);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [9:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) b = 0;
      else if (sel < 9) b = 10'(1 << $urandom_range(0, 9));
      else b = 10'($urandom);
      cyc(($urandom_range(0, 299) == 0), b,
          ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    idle(2);
    @(posedge clk); #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
